bp_stream_rr_arbiter: RTL and testbench

Round-robin arbiter that merges `num_req_p` BedRock memory streams (header plus one data beat per transfer) onto a single stream bus feeding a stream pump or memory endpoint. Arbitration is done per message, not per beat. Once a multi-beat message wins, the grant stays on that requester until its last beat transfers. This keeps beats of different messages from interleaving on the shared bus. Used in front of the LCE/CCE memory ports where several engines share one stream sink.

---
 rtl/bp_stream_rr_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_bp_stream_rr_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_stream_rr_arbiter.sv
// bp_stream_rr_arbiter
//
// Merges num_req_p BedRock memory streams onto a single stream bus. The
// arbiter decides once per message, not once per beat. A multi-beat message
// keeps the grant from its first beat through its last. Beats of different
// messages therefore never interleave on the shared bus.
//
// Handshake: every stream here uses valid/ready-and semantics. A beat moves
// on a cycle where valid and ready are both high. Valid never depends on
// ready. Ready toward a requester is the sink's ready, gated by the grant.
// So req_v_i[i] & req_ready_and_o[i] always equals mem_v_o & mem_ready_and_i
// on the granted index.
//
// Header layout (LSB first):
//   [3:0]                         msg_type
//   [4 +: paddr_width_p]          addr
//   [4+paddr_width_p +: 3]        size (bytes = 1 << size)
//   [7+paddr_width_p +: ...]      payload (lce id, way id)
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   req_header_i        per-requester message header
//   req_data_i          per-requester data beat
//   req_v_i             per-requester valid
//   req_ready_and_o     per-requester ready
//   mem_header_o        header of the granted requester
//   mem_data_o          data beat of the granted requester
//   mem_v_o             valid toward the sink
//   mem_ready_and_i     sink ready
//   grant_o             one-hot grant for this cycle (zero if none)
//   locked_o            high while a multi-beat message holds the bus
//                       (also serves as the FSM state debug output)
module bp_stream_rr_arbiter
  #(parameter int          paddr_width_p       = 40
  , parameter int          lce_id_width_p      = 4
  , parameter int          lce_assoc_p         = 8
  , parameter int          cce_block_width_p   = 512
  , parameter int          num_req_p           = 2
  , parameter int          stream_data_width_p = 64
  , parameter int          block_width_p       = cce_block_width_p
  , parameter logic [15:0] payload_mask_p      = 16'h0000
  , parameter int          header_width_p      = 4 + paddr_width_p + 3
                                                 + lce_id_width_p + $clog2(lce_assoc_p)
  )
  (input  logic                                          clk_i
  , input  logic                                         reset_i
  , input  logic [num_req_p-1:0][header_width_p-1:0]     req_header_i
  , input  logic [num_req_p-1:0][stream_data_width_p-1:0] req_data_i
  , input  logic [num_req_p-1:0]                         req_v_i
  , output logic [num_req_p-1:0]                         req_ready_and_o
  , output logic [header_width_p-1:0]                    mem_header_o
  , output logic [stream_data_width_p-1:0]               mem_data_o
  , output logic                                         mem_v_o
  , input  logic                                         mem_ready_and_i
  , output logic [num_req_p-1:0]                         grant_o
  , output logic                                         locked_o
  );

  localparam int lg_req_lp        = $clog2(num_req_p);
  localparam int max_beats_lp     = block_width_p / stream_data_width_p;
  localparam int cnt_width_lp     = $clog2(max_beats_lp) + 1;
  localparam int lg_beat_bytes_lp = $clog2(stream_data_width_p / 8);
  localparam int size_lsb_lp      = 4 + paddr_width_p;

  typedef enum logic [0:0] {
    e_idle   = 1'b0,
    e_stream = 1'b1
  } state_e;

  state_e                  r_state, w_state_n;
  logic [lg_req_lp-1:0]    r_last, w_last_n;
  logic [lg_req_lp-1:0]    r_gnt, w_gnt_n;
  logic [cnt_width_lp-1:0] r_rem, w_rem_n;

  logic [lg_req_lp-1:0]    w_pick;
  logic                    w_pick_v;
  logic [lg_req_lp-1:0]    w_sel;
  logic                    w_sel_v;
  logic                    w_xfer;

  logic [3:0]              w_msg_type;
  logic [2:0]              w_size;
  logic [7:0]              w_size_bytes;
  logic [7:0]              w_beats_raw;
  logic [cnt_width_lp-1:0] w_beats;

  // Requester index k positions after base, wrapping at num_req_p.
  function automatic logic [lg_req_lp-1:0] rr_idx(input logic [lg_req_lp-1:0] base,
                                                   input int k);
    int s;
    s = (int'(base) + k) % num_req_p;
    return lg_req_lp'(s);
  endfunction

  // Round-robin pick. Walking the offsets from far to near lets the nearest
  // valid requester after r_last overwrite any farther one, so no early exit
  // is needed.
  always_comb begin
    w_pick   = '0;
    w_pick_v = 1'b0;
    for (int k = num_req_p; k >= 1; k--) begin
      if (req_v_i[rr_idx(r_last, k)]) begin
        w_pick   = rr_idx(r_last, k);
        w_pick_v = 1'b1;
      end
    end
  end

  // Output mux. Only the owner is visible while streaming, even if it
  // bubbles.
  always_comb begin
    w_sel           = (r_state == e_stream) ? r_gnt : w_pick;
    w_sel_v         = (r_state == e_stream) ? 1'b1 : w_pick_v;
    mem_v_o         = (r_state == e_stream) ? req_v_i[r_gnt] : w_pick_v;
    mem_header_o    = req_header_i[w_sel];
    mem_data_o      = req_data_i[w_sel];
    grant_o         = '0;
    req_ready_and_o = '0;
    if (w_sel_v) begin
      grant_o[w_sel]         = 1'b1;
      req_ready_and_o[w_sel] = mem_ready_and_i;
    end
    locked_o = (r_state == e_stream);
  end

  assign w_xfer = mem_v_o & mem_ready_and_i;

  // Beat count of the message on the bus. Payloads smaller than one beat
  // still take one beat. Sizes beyond a block are clamped so the counter
  // cannot wrap.
  assign w_msg_type   = mem_header_o[3:0];
  assign w_size       = mem_header_o[size_lsb_lp +: 3];
  assign w_size_bytes = 8'd1 << w_size;
  assign w_beats_raw  = w_size_bytes >> lg_beat_bytes_lp;

  always_comb begin
    w_beats = cnt_width_lp'(1);
    if (payload_mask_p[w_msg_type] && (w_beats_raw > 8'd1)) begin
      if (w_beats_raw > 8'(max_beats_lp)) begin
        w_beats = cnt_width_lp'(max_beats_lp);
      end else begin
        w_beats = cnt_width_lp'(w_beats_raw);
      end
    end
  end

  // Next-state logic. The priority pointer moves only when a message
  // completes. While the sink stalls, the pick is recomputed but nothing
  // commits.
  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_gnt_n   = r_gnt;
    w_rem_n   = r_rem;
    case (r_state)
      e_idle: begin
        if (w_xfer) begin
          if (w_beats == cnt_width_lp'(1)) begin
            w_last_n = w_pick;
          end else begin
            w_state_n = e_stream;
            w_gnt_n   = w_pick;
            w_rem_n   = w_beats - cnt_width_lp'(1);
          end
        end
      end
      e_stream: begin
        if (w_xfer) begin
          w_rem_n = r_rem - cnt_width_lp'(1);
          if (r_rem == cnt_width_lp'(1)) begin
            w_state_n = e_idle;
            w_last_n  = r_gnt;
          end
        end
      end
      default: w_state_n = e_idle;
    endcase
  end

  // After reset, r_last points at the top requester so requester 0 is
  // searched first.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_last  <= lg_req_lp'(num_req_p - 1);
      r_gnt   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_n;
      r_last  <= w_last_n;
      r_gnt   <= w_gnt_n;
      r_rem   <= w_rem_n;
    end
  end

endmodule

// File: tb/tb_bp_stream_rr_arbiter.sv
// Bench for bp_stream_rr_arbiter: four requesters, 64-bit beats, 512-bit
// blocks, and payload carried by wr (type 1) and uc_wr (type 3).
module tb_bp_stream_rr_arbiter;
  localparam int          N        = 4;
  localparam int          DW       = 64;
  localparam int          PADDR    = 40;
  localparam int          HW       = 4 + PADDR + 3 + 4 + 3;
  localparam int          SIZE_LSB = 4 + PADDR;
  localparam int          PAY_LSB  = SIZE_LSB + 3;
  localparam logic [15:0] MASK     = 16'h000A;
  localparam logic [3:0]  T_WR     = 4'd1;
  localparam logic [3:0]  T_UC_RD  = 4'd2;
  localparam logic [3:0]  T_UC_WR  = 4'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][HW-1:0] req_hdr;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_v;
  logic [N-1:0]         req_rdy;
  logic [HW-1:0]        mem_hdr;
  logic [DW-1:0]        mem_data;
  logic                 mem_v;
  logic                 mem_rdy;
  logic [N-1:0]         grant;
  logic                 locked;

  bp_stream_rr_arbiter #(
    .paddr_width_p(PADDR), .lce_id_width_p(4), .lce_assoc_p(8),
    .cce_block_width_p(512), .num_req_p(N), .stream_data_width_p(DW),
    .block_width_p(512), .payload_mask_p(MASK), .header_width_p(HW)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .req_header_i(req_hdr), .req_data_i(req_data), .req_v_i(req_v),
    .req_ready_and_o(req_rdy),
    .mem_header_o(mem_hdr), .mem_data_o(mem_data), .mem_v_o(mem_v),
    .mem_ready_and_i(mem_rdy),
    .grant_o(grant), .locked_o(locked)
  );

  typedef struct packed {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         rq[N][$];
  int            xfer_cnt[N];
  int            popped[N];
  int            hold_off[N];
  int            glog[$];
  logic [DW-1:0] exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            m_last, m_owner, m_left;
  bit            gate_rand  = 1'b0;
  int            ready_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input logic [HW-1:0] h);
    logic [15:0] mask_v;
    int          bytes;
    mask_v = MASK;
    bytes  = 1 << int'(h[SIZE_LSB +: 3]);
    if (!mask_v[h[3:0]]) return 1;
    return (bytes / 8 < 1) ? 1 : bytes / 8;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic int pending();
    int p = 0;
    for (int r = 0; r < N; r++) p += rq[r].size() - (xfer_cnt[r] - popped[r]);
    return p;
  endfunction

  // Queue one whole message (all its beats) on requester r.
  task automatic push_msg(input int r, input logic [3:0] typ, input logic [2:0] size);
    logic [HW-1:0] h;
    beat_t         bt;
    int            b;
    h = '0;
    h[3:0]          = typ;
    h[4 +: PADDR]   = {8'h00, $urandom()};
    h[SIZE_LSB +: 3] = size;
    h[PAY_LSB +: 7] = 7'($urandom());
    b = beats_of(h);
    for (int i = 0; i < b; i++) begin
      bt.hdr  = h;
      bt.data = {$urandom(), $urandom()};
      rq[r].push_back(bt);
    end
  endtask

  // Reference model: grant ownership per message, round-robin among valid
  // requesters after the last completed owner.
  task automatic model_check();
    int           sel;
    logic [N-1:0] eg, er;
    logic         ev;
    int           b;
    if (rst) begin
      m_last  = N - 1;
      m_owner = -1;
      m_left  = 0;
    end
    sel = -1;
    if (m_owner >= 0) sel = m_owner;
    else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (sel < 0 && req_v[c]) sel = c;
      end
    end
    eg = '0; er = '0; ev = 1'b0;
    if (sel >= 0) begin
      eg[sel] = 1'b1;
      er[sel] = mem_rdy;
      ev      = req_v[sel];
    end
    check("grant", grant, eg);
    check("ready", req_rdy, er);
    check("mem_v", mem_v, ev);
    check("locked", locked, m_owner >= 0);
    if (ev) check("header", mem_hdr, req_hdr[sel]);
    if (!rst) begin
      check("xfer_match", mem_v & mem_rdy, ev & mem_rdy);
      if (ev && mem_rdy) exp_q.push_back(req_data[sel]);
      if (mem_v && mem_rdy) begin
        glog.push_back(onehot_idx(grant));
        if (exp_q.size() > 0) check("data", mem_data, exp_q.pop_front());
      end
      if (ev && mem_rdy) begin
        xfer_cnt[sel]++;
        if (m_owner < 0) begin
          b = beats_of(req_hdr[sel]);
          if (b > 1) begin
            m_owner = sel;
            m_left  = b - 1;
          end else begin
            m_last = sel;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_last  = m_owner;
            m_owner = -1;
          end
        end
      end
    end
  endtask

  // Driver: retire beats the model saw transfer, present queue heads, then
  // check at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      while (popped[r] < xfer_cnt[r]) begin
        if (rq[r].size() > 0) rq[r].delete(0);
        popped[r]++;
      end
      if (rq[r].size() > 0 && hold_off[r] == 0 &&
          (!gate_rand || $urandom_range(0, 3) != 0)) begin
        req_v[r]    = 1'b1;
        req_hdr[r]  = rq[r][0].hdr;
        req_data[r] = rq[r][0].data;
      end else begin
        req_v[r] = 1'b0;
      end
      if (hold_off[r] > 0) hold_off[r]--;
    end
    mem_rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    model_check();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, pending(), 0);
  endtask

  task automatic wait_cnt(input int r, input int target, input int budget, input string name);
    int n = 0;
    while (xfer_cnt[r] < target && n < budget) begin
      step();
      n++;
    end
    check(name, xfer_cnt[r] >= target, 1'b1);
  endtask

  task automatic clear_all();
    for (int r = 0; r < N; r++) begin
      rq[r].delete();
      popped[r]   = xfer_cnt[r];
      hold_off[r] = 0;
    end
    req_v = '0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_all();
    repeat (2) step();
    #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int fstart;
    int cnt[N];
    req_v    = '0;
    req_hdr  = '0;
    req_data = '0;
    mem_rdy  = 1'b1;
    for (int r = 0; r < N; r++) begin
      xfer_cnt[r] = 0;
      popped[r]   = 0;
      hold_off[r] = 0;
    end

    // Reset state
    step();
    check("rst_locked", locked, 1'b0);
    check("rst_grant", grant, 4'b0000);
    check("rst_mem_v", mem_v, 1'b0);
    step();
    #1 rst = 1'b0;

    // Reset priority: requester 0 first, then alternation
    for (int i = 0; i < 2; i++) begin
      push_msg(0, T_UC_RD, 3'd3);
      push_msg(1, T_UC_RD, 3'd3);
    end
    step(); check("prio_c0", grant, 4'b0001);
    step(); check("prio_c1", grant, 4'b0010);
    step(); check("prio_c2", grant, 4'b0001);
    step(); check("prio_c3", grant, 4'b0010);
    wait_idle(20, "prio_drain");

    // Message lock: 8-beat wr from requester 1, requester 0 valid throughout
    push_msg(0, T_UC_RD, 3'd3);
    step(); check("lock_pre", grant, 4'b0001);
    push_msg(1, T_WR, 3'd6);
    for (int i = 0; i < 10; i++) push_msg(0, T_UC_RD, 3'd2);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("lock_grant", grant, 4'b0010);
      check("lock_locked", locked, (i >= 2) ? 1'b1 : 1'b0);
    end
    step();
    check("lock_release_grant", grant, 4'b0001);
    check("lock_release_locked", locked, 1'b0);
    wait_idle(40, "lock_drain");

    // Sub-beat payload: 4 B is one beat, 16 B is two
    push_msg(2, T_UC_WR, 3'd2);
    step(); check("sub4_grant", grant, 4'b0100); check("sub4_locked", locked, 1'b0);
    step(); check("sub4_after", grant, 4'b0000); check("sub4_after_lk", locked, 1'b0);
    push_msg(2, T_UC_WR, 3'd4);
    step(); check("sub16_b1_grant", grant, 4'b0100); check("sub16_b1_lk", locked, 1'b0);
    step(); check("sub16_b2_grant", grant, 4'b0100); check("sub16_b2_lk", locked, 1'b1);
    step(); check("sub16_done_lk", locked, 1'b0); check("sub16_done_g", grant, 4'b0000);

    // Backpressure and bubbles in the middle of a locked message
    ready_mode = 1;
    base = xfer_cnt[1];
    push_msg(1, T_WR, 3'd6);
    for (int i = 0; i < 6; i++) push_msg(0, T_UC_RD, 3'd1);
    wait_cnt(1, base + 2, 200, "bp_reach_beat2");
    hold_off[1] = 3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_bubble_v", mem_v, 1'b0);
      check("bp_bubble_lk", locked, 1'b1);
      check("bp_bubble_g", grant, 4'b0010);
      check("bp_other_rdy", req_rdy[0], 1'b0);
    end
    wait_idle(400, "bp_drain");
    check("bp_beats", xfer_cnt[1] - base, 8);
    ready_mode = 0;

    // Asynchronous reset after beat 3 of 8
    base = xfer_cnt[1];
    push_msg(1, T_WR, 3'd6);
    wait_cnt(1, base + 3, 50, "mrst_reach_beat3");
    @(posedge clk);
    #2;
    clear_all();
    #1 rst = 1'b1;
    #1;
    check("mrst_locked", locked, 1'b0);
    check("mrst_grant", grant, 4'b0000);
    check("mrst_beats", xfer_cnt[1] - base, 3);
    repeat (2) step();
    #1 rst = 1'b0;
    push_msg(1, T_UC_RD, 3'd3);
    push_msg(0, T_UC_RD, 3'd3);
    step(); check("mrst_next_g", grant, 4'b0001); check("mrst_next_lk", locked, 1'b0);
    step(); check("mrst_next2_g", grant, 4'b0010);
    wait_idle(20, "mrst_drain");

    // Fairness across four continuously valid requesters
    apply_reset();
    fstart = glog.size();
    for (int i = 0; i < 25; i++)
      for (int r = 0; r < N; r++) push_msg(r, T_UC_RD, 3'd3);
    wait_idle(300, "fair_drain");
    check("fair_total", glog.size() - fstart, 100);
    for (int r = 0; r < N; r++) cnt[r] = 0;
    for (int i = 0; i < 100 && fstart + i < glog.size(); i++) begin
      check("fair_order", glog[fstart + i], i % N);
      if (glog[fstart + i] >= 0 && glog[fstart + i] < N) cnt[glog[fstart + i]]++;
    end
    for (int r = 0; r < N; r++) check("fair_count", cnt[r], 25);

    // Random traffic: mixed types and sizes, valid bubbles, random sink ready
    ready_mode = 1;
    gate_rand  = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (rq[r].size() < 20) push_msg(r, 4'($urandom_range(0, 5)), 3'($urandom_range(0, 6)));
      end
      step();
    end
    gate_rand = 1'b0;
    wait_idle(3000, "rand_drain");
    check("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
